// File: rtl/rubiks_pkg.sv
// Shared definitions for the cube solver: face indices, turn codes, move-code layout
// and the movement sequencer's state encoding.
package rubiks_pkg;

   localparam int unsigned NUM_FACES = 6;
   localparam int unsigned CODE_W    = 5;

   localparam logic [2:0] FACE_U = 3'd0;
   localparam logic [2:0] FACE_D = 3'd1;
   localparam logic [2:0] FACE_F = 3'd2;
   localparam logic [2:0] FACE_B = 3'd3;
   localparam logic [2:0] FACE_L = 3'd4;
   localparam logic [2:0] FACE_R = 3'd5;

   localparam logic [1:0] TURN_CW  = 2'b00;
   localparam logic [1:0] TURN_CCW = 2'b01;
   localparam logic [1:0] TURN_180 = 2'b10;
   localparam logic [1:0] TURN_INV = 2'b11;

   localparam int unsigned FACE_MSB = 4;
   localparam int unsigned FACE_LSB = 2;
   localparam int unsigned TURN_MSB = 1;
   localparam int unsigned TURN_LSB = 0;

   typedef enum logic [2:0] {
      StIdle     = 3'b000,
      StLoad     = 3'b001,
      StStepHigh = 3'b010,
      StStepLow  = 3'b011,
      StSettle   = 3'b100,
      StDone     = 3'b101
   } estado_t;

   function automatic logic codigo_valido(input logic [CODE_W-1:0] codigo);
      return (codigo[FACE_MSB:FACE_LSB] <= FACE_R) && (codigo[TURN_MSB:TURN_LSB] != TURN_INV);
   endfunction

   // Faces 6 and 7 shift out of the vector and yield an empty mask.
   function automatic logic [NUM_FACES-1:0] mascara_face(input logic [2:0] face);
      return NUM_FACES'(1) << face;
   endfunction

endpackage

// File: rtl/temporizador_passo.sv
// Loadable down-counter; expira_o flags the last cycle of a loaded interval, so a load
// of V gives exactly V cycles before the next reload point.
module temporizador_passo #(
   parameter int unsigned LARGURA = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               carrega_i,
   input  logic [LARGURA-1:0] valor_i,
   output logic               expira_o
);

   logic [LARGURA-1:0] contagem_q, contagem_d;

   always_comb begin
      contagem_d = contagem_q;
      if (carrega_i) begin
         contagem_d = valor_i;
      end else if (contagem_q != '0) begin
         contagem_d = contagem_q - LARGURA'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         contagem_q <= '0;
      end else begin
         contagem_q <= contagem_d;
      end
   end

   assign expira_o = (contagem_q == LARGURA'(1));

endmodule

// File: rtl/sequenciador_movimento.sv
// Movement sequencer: turns one move code into step pulses on the selected face motor,
// holds for a settle interval and answers with a one-cycle done pulse.
module sequenciador_movimento
   import rubiks_pkg::*;
#(
   parameter int unsigned STEPS_90      = 50,
   parameter int unsigned HALF_PERIOD   = 25000,
   parameter int unsigned SETTLE_CYCLES = 500000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 aciona_movimento_i,
   input  logic [CODE_W-1:0]    codigo_movimento_i,
   output logic [NUM_FACES-1:0] motor_step_o,
   output logic [NUM_FACES-1:0] motor_dir_o,
   output logic [NUM_FACES-1:0] motor_en_o,
   output logic                 fim_movimento_o,
   output logic                 erro_codigo_o,
   output logic                 ocupado_o,
   output logic [2:0]           db_estado_o
);

   localparam int unsigned PassosW   = $clog2(2 * STEPS_90 + 1);
   localparam int unsigned MaxTempo  = (HALF_PERIOD > SETTLE_CYCLES) ? HALF_PERIOD : SETTLE_CYCLES;
   localparam int unsigned TimerW    = $clog2(MaxTempo + 1);

   estado_t             estado_q, estado_d;
   logic [CODE_W-1:0]   codigo_q, codigo_d;
   logic [PassosW-1:0]  passos_q, passos_d;
   logic                erro_q, erro_d;

   logic                carrega;
   logic [TimerW-1:0]   valor_carga;
   logic                expira;

   logic                valido;
   logic [1:0]          giro;
   logic [NUM_FACES-1:0] mascara;
   logic [NUM_FACES-1:0] mascara_dir;

   temporizador_passo #(
      .LARGURA (TimerW)
   ) u_temporizador (
      .clock     (clock),
      .reset     (reset),
      .carrega_i (carrega),
      .valor_i   (valor_carga),
      .expira_o  (expira)
   );

   assign valido      = codigo_valido(codigo_q);
   assign giro        = codigo_q[TURN_MSB:TURN_LSB];
   assign mascara     = valido ? mascara_face(codigo_q[FACE_MSB:FACE_LSB]) : '0;
   assign mascara_dir = (giro != TURN_CCW) ? mascara : '0;

   always_comb begin
      estado_d        = estado_q;
      codigo_d        = codigo_q;
      passos_d        = passos_q;
      erro_d          = erro_q;
      carrega         = 1'b0;
      valor_carga     = TimerW'(HALF_PERIOD);
      motor_step_o    = '0;
      motor_dir_o     = '0;
      motor_en_o      = '0;
      fim_movimento_o = 1'b0;
      erro_codigo_o   = 1'b0;
      ocupado_o       = 1'b1;

      unique case (estado_q)
         StIdle: begin
            ocupado_o = 1'b0;
            if (aciona_movimento_i) begin
               codigo_d = codigo_movimento_i;
               estado_d = StLoad;
            end
         end
         StLoad: begin
            motor_en_o  = mascara;
            motor_dir_o = mascara_dir;
            if (!valido) begin
               erro_d   = 1'b1;
               estado_d = StDone;
            end else begin
               passos_d = (giro == TURN_180) ? PassosW'(2 * STEPS_90) : PassosW'(STEPS_90);
               carrega  = 1'b1;
               estado_d = StStepHigh;
            end
         end
         StStepHigh: begin
            motor_step_o = mascara;
            motor_en_o   = mascara;
            motor_dir_o  = mascara_dir;
            if (expira) begin
               carrega  = 1'b1;
               estado_d = StStepLow;
            end
         end
         StStepLow: begin
            motor_en_o  = mascara;
            motor_dir_o = mascara_dir;
            if (expira) begin
               passos_d = passos_q - PassosW'(1);
               carrega  = 1'b1;
               // Last pulse done: the same timer now counts the settle hold.
               if (passos_q == PassosW'(1)) begin
                  valor_carga = TimerW'(SETTLE_CYCLES);
                  estado_d    = StSettle;
               end else begin
                  estado_d = StStepHigh;
               end
            end
         end
         StSettle: begin
            motor_en_o  = mascara;
            motor_dir_o = mascara_dir;
            if (expira) begin
               estado_d = StDone;
            end
         end
         StDone: begin
            fim_movimento_o = 1'b1;
            erro_codigo_o   = erro_q;
            erro_d          = 1'b0;
            estado_d        = StIdle;
         end
         default: begin
            estado_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= StIdle;
         codigo_q <= '0;
         passos_q <= '0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         codigo_q <= codigo_d;
         passos_q <= passos_d;
         erro_q   <= erro_d;
      end
   end

   assign db_estado_o = estado_q;

endmodule

// File: tb/tb_sequenciador_movimento.sv
// Bench for sequenciador_movimento: directed and random moves checked cycle by cycle
// against a waveform model derived from the move code.
module tb_sequenciador_movimento;

   localparam int unsigned H  = 2;
   localparam int unsigned S  = 3;
   localparam int unsigned ST = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       aciona = 1'b0;
   logic [4:0] codigo = 5'd0;
   logic [5:0] step, dir, en;
   logic       fim, erro_cod, ocupado;
   logic [2:0] db_estado;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   sequenciador_movimento #(
      .STEPS_90      (ST),
      .HALF_PERIOD   (H),
      .SETTLE_CYCLES (S)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .aciona_movimento_i (aciona),
      .codigo_movimento_i (codigo),
      .motor_step_o       (step),
      .motor_dir_o        (dir),
      .motor_en_o         (en),
      .fim_movimento_o    (fim),
      .erro_codigo_o      (erro_cod),
      .ocupado_o          (ocupado),
      .db_estado_o        (db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_step"}, 32'(step), 32'd0);
      chk({tag, "_dir"}, 32'(dir), 32'd0);
      chk({tag, "_en"}, 32'(en), 32'd0);
      chk({tag, "_fim"}, 32'(fim), 32'd0);
      chk({tag, "_erro"}, 32'(erro_cod), 32'd0);
      chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
      chk({tag, "_estado"}, 32'(db_estado), 32'd0);
   endtask

   // Entered at the negedge of an IDLE cycle t; returns at the negedge of the DONE cycle.
   task automatic run_move(input logic [4:0] code, input bit hold, input logic [4:0] mid_code);
      int unsigned face, turn, n, lat, edges;
      bit          valid, exp_step, cur, prev;
      logic [5:0]  mask, dmask;
      face  = 32'(code[4:2]);
      turn  = 32'(code[1:0]);
      valid = (face < 6) && (turn != 3);
      n     = !valid ? 0 : ((turn == 2) ? 2 * ST : ST);
      lat   = valid ? 2 + 2 * H * n + S : 2;
      mask  = valid ? 6'(1 << face) : 6'd0;
      dmask = (valid && turn != 1) ? mask : 6'd0;
      edges = 0;
      prev  = 1'b0;

      aciona = 1'b1;
      codigo = code;
      #1;
      chk("idle_ocupado", 32'(ocupado), 32'd0);
      chk("idle_en", 32'(en), 32'd0);
      for (int c = 1; c <= int'(lat); c++) begin
         @(negedge clock);
         if (c == 1) aciona = hold;
         if (c == 3) codigo = mid_code;
         exp_step = valid && (c >= 2) && (c < int'(2 + 2 * H * n)) && (((c - 2) / H) % 2 == 0);
         chk("step", 32'(step), exp_step ? 32'(mask) : 32'd0);
         chk("en", 32'(en), (c < int'(lat)) ? 32'(mask) : 32'd0);
         chk("dir", 32'(dir), (c < int'(lat)) ? 32'(dmask) : 32'd0);
         chk("fim", 32'(fim), (c == int'(lat)) ? 32'd1 : 32'd0);
         chk("erro_codigo", 32'(erro_cod), (c == int'(lat) && !valid) ? 32'd1 : 32'd0);
         chk("ocupado", 32'(ocupado), 32'd1);
         if (c == 1) chk("estado_load", 32'(db_estado), 32'd1);
         if (c == int'(lat)) chk("estado_done", 32'(db_estado), 32'd5);
         cur = |(step & mask);
         if (cur && !prev) edges++;
         prev = cur;
      end
      chk("step_edges", edges, n);
   endtask

   initial begin
      logic [4:0] rc, rm;
      repeat (2) @(negedge clock);
      chk_all_zero("reset");
      reset = 1'b0;
      @(negedge clock);
      chk_all_zero("post_reset");

      // Directed moves: valid CW / 180 / CCW, then both invalid forms.
      run_move(5'b01000, 1'b0, 5'b10110);
      @(negedge clock);
      run_move(5'b10110, 1'b0, 5'b00001);
      @(negedge clock);
      run_move(5'b00001, 1'b0, 5'b11111);
      @(negedge clock);
      run_move(5'b11000, 1'b0, 5'b00000);
      @(negedge clock);
      run_move(5'b00011, 1'b0, 5'b00000);
      @(negedge clock);

      // Start held high through the move with a mid-move code change: restart after DONE.
      run_move(5'b00110, 1'b1, 5'b10101);
      @(negedge clock);
      run_move(5'b10101, 1'b0, 5'b01010);
      @(negedge clock);

      // Reset while in STEP_HIGH.
      aciona = 1'b1;
      codigo = 5'b01000;
      @(negedge clock);
      aciona = 1'b0;
      @(negedge clock);
      chk("pre_reset_step", 32'(step), 32'h04);
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      @(negedge clock);
      chk_all_zero("held_reset");
      reset = 1'b0;
      @(negedge clock);
      run_move(5'b01000, 1'b0, 5'b00100);
      @(negedge clock);

      // Random moves, including invalid codes and random mid-move code changes.
      for (int i = 0; i < 20; i++) begin
         rc = 5'($urandom_range(0, 31));
         rm = 5'($urandom_range(0, 31));
         run_move(rc, 1'b0, rm);
         @(negedge clock);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
